// File: rtl/vset_cfg_unit.sv
// vset_cfg_unit: handles vsetvli / vsetivli / vsetvl requests.
// Decodes vtype into SEW, LMUL and VLMAX, checks legality against ELEN,
// computes the new vl and holds the architectural vl/vtype state.
// The result goes back as rd write-back data over a valid/ready handshake.
module vset_cfg_unit #(
  parameter int VLEN = 128,
  parameter int ELEN = 64,
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_imm,
  input  logic [XLEN-1:0]        avl_i,
  input  logic [4:0]             uimm,
  input  logic                   rs1_is_x0,
  input  logic                   rd_is_x0,
  input  logic [XLEN-1:0]        vtype_i,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [XLEN-1:0]        resp_vl,
  output logic [$clog2(VLEN):0]  vl_o,
  output logic [XLEN-1:0]        vtype_o,
  output logic [7:0]             sew_o,
  output logic [$clog2(VLEN):0]  vlmax_o
);

  localparam int VL_W      = $clog2(VLEN) + 1;
  localparam int LOG2_VLEN = $clog2(VLEN);
  localparam int LOG2_ELEN = $clog2(ELEN);
  localparam logic [XLEN-1:0] VILL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DEC, EXE, RSP} state_t;

  state_t state_reg, state_next;

  // Request fields captured at the accept handshake
  logic            req_imm_reg;
  logic            rs1_is_x0_reg;
  logic            rd_is_x0_reg;
  logic [XLEN-1:0] avl_reg;
  logic [XLEN-1:0] vtype_req_reg;
  logic [4:0]      uimm_reg;

  // Decode stage results; sew_log is log2(SEW)-3
  logic [1:0]        sew_log_reg, sew_log_next;
  logic [7:0]        sew_dec_reg, sew_dec_next;
  logic signed [2:0] lmul_exp_reg, lmul_exp_next;
  logic              illegal_reg, illegal_next;

  // Architectural state and response data
  logic [VL_W-1:0] vl_reg;
  logic [VL_W-1:0] vlmax_reg;
  logic [XLEN-1:0] vtype_reg;
  logic [XLEN-1:0] resp_vl_reg;
  logic [7:0]      sew_reg;

  // Execute stage combinational results
  logic [2:0]      vsew;
  logic [2:0]      vlmul;
  int              sew_log_i;
  int              frac_log_i;
  int              shamt;
  logic [VL_W-1:0] vlmax_calc;
  logic [XLEN-1:0] vlmax_x;
  logic [XLEN-1:0] avl_sel;
  logic            use_avl;
  logic [XLEN-1:0] vl_x;
  logic            vill_next;

  // State register; reset always returns to IDLE and drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = DEC;
      end
      DEC: state_next = EXE;
      EXE: state_next = RSP;
      RSP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture all request fields on the accept handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      req_imm_reg   <= 1'b0;
      rs1_is_x0_reg <= 1'b0;
      rd_is_x0_reg  <= 1'b0;
      avl_reg       <= '0;
      vtype_req_reg <= '0;
      uimm_reg      <= '0;
    end else if (state_reg == IDLE && req_valid) begin
      req_imm_reg   <= req_imm;
      rs1_is_x0_reg <= rs1_is_x0;
      rd_is_x0_reg  <= rd_is_x0;
      avl_reg       <= avl_i;
      vtype_req_reg <= vtype_i;
      uimm_reg      <= uimm;
    end
  end

  // vtype decode: vlmul read as 3-bit two's complement is the LMUL exponent,
  // so 100 (-4) is the reserved encoding
  always_comb begin
    vsew          = vtype_req_reg[5:3];
    vlmul         = vtype_req_reg[2:0];
    sew_log_i     = int'(vsew[1:0]);
    frac_log_i    = 8 - int'(vlmul);
    sew_log_next  = vsew[1:0];
    sew_dec_next  = 8'd8 << vsew[1:0];
    lmul_exp_next = vlmul;
    illegal_next  = 1'b0;
    if (vsew[2])                                            illegal_next = 1'b1;
    if (sew_log_i + 3 > LOG2_ELEN)                          illegal_next = 1'b1;
    if (vlmul == 3'b100)                                    illegal_next = 1'b1;
    if (vlmul[2] && (sew_log_i + 3 + frac_log_i > LOG2_ELEN)) illegal_next = 1'b1;
    if (|vtype_req_reg[XLEN-1:8])                           illegal_next = 1'b1;
  end

  // Decode stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sew_log_reg  <= '0;
      sew_dec_reg  <= '0;
      lmul_exp_reg <= '0;
      illegal_reg  <= 1'b0;
    end else if (state_reg == DEC) begin
      sew_log_reg  <= sew_log_next;
      sew_dec_reg  <= sew_dec_next;
      lmul_exp_reg <= lmul_exp_next;
      illegal_reg  <= illegal_next;
    end
  end

  // VLMAX by shift and new vl selection; legal configurations never need a
  // negative shift because SEW/LMUL <= ELEN <= VLEN
  always_comb begin
    shamt     = LOG2_VLEN - 3 - int'(sew_log_reg) + int'(lmul_exp_reg);
    vill_next = illegal_reg;
    if (illegal_reg || shamt < 0) vlmax_calc = '0;
    else                          vlmax_calc = VL_W'(1) << shamt;
    vlmax_x = XLEN'(vlmax_calc);
    use_avl = 1'b1;
    avl_sel = avl_reg;
    if (req_imm_reg)         avl_sel = XLEN'(uimm_reg);
    else if (!rs1_is_x0_reg) avl_sel = avl_reg;
    else                     use_avl = 1'b0;
    if (use_avl) begin
      vl_x = (avl_sel < vlmax_x) ? avl_sel : vlmax_x;
    end else if (!rd_is_x0_reg) begin
      vl_x = vlmax_x;
    end else begin
      // rs1 = rd = x0: keep vl, only valid if it still fits the new VLMAX
      vl_x = XLEN'(vl_reg);
      if (vtype_reg[XLEN-1] || XLEN'(vl_reg) > vlmax_x) vill_next = 1'b1;
    end
    if (vill_next) vl_x = '0;
  end

  // Architectural update happens only on the EXE->RSP edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vl_reg      <= '0;
      vlmax_reg   <= '0;
      vtype_reg   <= VILL;
      sew_reg     <= '0;
      resp_vl_reg <= '0;
    end else if (state_reg == EXE) begin
      vl_reg      <= VL_W'(vl_x);
      resp_vl_reg <= vl_x;
      vtype_reg   <= vill_next ? VILL : XLEN'(vtype_req_reg[7:0]);
      sew_reg     <= vill_next ? 8'd0 : sew_dec_reg;
      vlmax_reg   <= vill_next ? '0 : vlmax_calc;
    end
  end

  assign resp_vl = resp_vl_reg;
  assign vl_o    = vl_reg;
  assign vtype_o = vtype_reg;
  assign sew_o   = sew_reg;
  assign vlmax_o = vlmax_reg;

endmodule
